u_butterfly_pipelined: RTL and testbench
========================================

# u_butterfly_pipelined

Pipelined radix-2 butterfly for signed fixed-point data, selectable per sample between decimation-in-time (DIT) and decimation-in-frequency (DIF) forms. Accepts one (a, b, w) triple plus mode bit every clock and produces the two butterfly outputs at double width two cycles later. It is the arithmetic core instantiated by the FFT datapath stages. Twiddle `w` is a real signed integer; complex handling is outside this block.

## Interface
- `DATA_W`, default 8: width of the signed inputs `a`, `b` and `w`.
- `OUT_W`, default 2*DATA_W: width of the signed outputs. It must equal 2*DATA_W and is not independently settable.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `a`  in  DATA_W: signed upper input.
- `b`  in  DATA_W: signed lower input.
- `w`  in  DATA_W: signed twiddle factor.
- `s`  in  1: mode select, 0 = DIT, 1 = DIF. Sampled together with the data.
- `outa`  out  OUT_W: signed upper output.
- `outb`  out  OUT_W: signed lower output.

## Operation
- DIT mode (s=0): `outa = a + w*b` and `outb = a - w*b`.
- DIF mode (s=1): `outa = a + b` and `outb = w*(a - b)`.
- All arithmetic is two's-complement signed. Inputs are sign-extended before any add, subtract or multiply.
- Intermediate widths:
  - `a ± b` is DATA_W+1 bits.
  - The multiplier is DATA_W × (DATA_W+1) bits, signed.
- The results fit OUT_W exactly for all input combinations, so there is no saturation or rounding.
  - Worst case is w=-2^(N-1) with a-b=∓(2^N-1), which gives |result| < 2^(2N-1).
  - Outputs are the exact result, truncated to OUT_W, which is lossless.
- A single shared multiplier serves both modes. Its operand is `b` in DIT and `(a-b)` in DIF.
- The mode bit travels down the pipeline with its data, so mode may change every cycle with no bubble.
- There is no valid/ready handshake. The block accepts a new sample every cycle, and the output is meaningful two cycles after its inputs.

## Timing
- Stage 1 (at clock edge k), registers:
  - `s`
  - sign-extended `a`
  - `a+b`
  - the multiplier operand (`b` or `a-b`, selected by `s`)
  - `w`
- Stage 2 (at edge k+1), computes and registers:
  - p = w_r × operand_r.
  - DIT: `outa = a_r + p` and `outb = a_r - p`.
  - DIF: `outa = sum_r` and `outb = p`.
- Latency: inputs sampled at edge k appear on `outa`/`outb` after edge k+1 and hold for one cycle. Throughput is 1 sample per clock.
- Outputs are driven directly from registers, with no combinational path from input to output.
- Reset (rst=0): all pipeline and output registers clear to 0 immediately, asynchronously. `outa` = `outb` = 0 while reset is held.
- Release of reset takes effect at the next rising edge. The first valid output appears two edges after the first post-reset sample.
- Reset asserted mid-stream discards all in-flight samples, and outputs read 0 until refilled.

## Structure
- Shared package: the `DATA_W` default, the `MODE_DIT=1'b0`/`MODE_DIF=1'b1` constants, and a signed sample typedef.
- One natural sub-module, `bfly_mult`: a signed DATA_W×(DATA_W+1) multiplier, combinational, placed in stage 2.
- Everything else (operand mux, adders, pipeline registers) stays in the top-level block.

## Test plan
- Reset held low with random inputs -> `outa`=`outb`=0. After release and 2 edges, the outputs track the stimulus.
- DIT, a=10, b=2, w=3 -> outa=16, outb=4, two cycles later.
- DIF, a=10, b=2, w=3 -> outa=12, outb=24. The same for a=-5, b=4, w=-2 -> -1, 18.
- Back-to-back alternating modes on consecutive cycles must all come out correct and in order:
  - s=0, (-5,4,-2) -> -13, 3
  - s=1, (-7,-3,2) -> -10, -8
  - s=0, (-7,-3,2) -> -13, -1
- Extremes at DATA_W=8:
  - DIF a=-128, b=127, w=-128 -> outa=-1, outb=32640.
  - DIT a=-128, b=-128, w=-128 -> outa=16256, outb=-16512.
- Reset asserted between samples -> outputs drop to 0 asynchronously, and no pre-reset sample emerges afterward.

Source files
------------

// File: rtl/u_butterfly_pipelined_pkg.sv
// Shared definitions for the pipelined radix-2 butterfly: default width,
// mode encodings and the signed sample type.
package u_butterfly_pipelined_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic MODE_DIT = 1'b0;
  localparam logic MODE_DIF = 1'b1;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/u_butterfly_pipelined_bfly_mult.sv
// Signed multiplier for the butterfly: DATA_W-bit twiddle times a
// (DATA_W+1)-bit operand. It is purely combinational and is used in stage 2.
module bfly_mult
  import u_butterfly_pipelined_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0]   w,
  input  logic signed [DATA_W:0]     x,
  output logic signed [2*DATA_W-1:0] p
);

  localparam int PW = 2 * DATA_W;

  // The exact product always fits in 2*DATA_W bits, so a multiply done
  // modulo 2^PW on sign-extended operands gives the exact result.
  assign p = PW'(w) * PW'(x);

endmodule

// File: rtl/u_butterfly_pipelined.sv
// Two-stage pipelined radix-2 butterfly, with DIT/DIF form chosen per sample.
// Stage 1 registers the operands and one shared multiplier serves both forms.
module u_butterfly_pipelined
  import u_butterfly_pipelined_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int OUT_W  = 2 * DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] w,
  input  logic                     s,
  output logic signed [OUT_W-1:0]  outa,
  output logic signed [OUT_W-1:0]  outb
);

  logic signed [DATA_W:0]   a_ext, b_ext, sum, diff, opnd;
  logic                     s_r;
  logic signed [DATA_W:0]   a_r, sum_r, opnd_r;
  logic signed [DATA_W-1:0] w_r;
  logic signed [OUT_W-1:0]  p, a_w, outa_next, outb_next;

  assign a_ext = {a[DATA_W-1], a};
  assign b_ext = {b[DATA_W-1], b};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;
  assign opnd  = (s == MODE_DIF) ? diff : b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r    <= MODE_DIT;
      a_r    <= '0;
      sum_r  <= '0;
      opnd_r <= '0;
      w_r    <= '0;
    end else begin
      s_r    <= s;
      a_r    <= a_ext;
      sum_r  <= sum;
      opnd_r <= opnd;
      w_r    <= w;
    end
  end

  bfly_mult #(.DATA_W(DATA_W)) u_mult (
    .w (w_r),
    .x (opnd_r),
    .p (p)
  );

  assign a_w = OUT_W'(a_r);

  always_comb begin
    outa_next = a_w + p;
    outb_next = a_w - p;
    if (s_r == MODE_DIF) begin
      outa_next = OUT_W'(sum_r);
      outb_next = p;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outa <= '0;
      outb <= '0;
    end else begin
      outa <= outa_next;
      outb <= outb_next;
    end
  end

endmodule

// File: tb/tb_u_butterfly_pipelined.sv
// Self-checking bench for u_butterfly_pipelined. A queue-based arithmetic
// reference model checks directed cases, random samples and reset behaviour.
module tb_u_butterfly_pipelined;
  import u_butterfly_pipelined_pkg::*;

  localparam int N = DATA_W_DEF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  sample_t               a, b, w;
  logic                  s;
  logic signed [2*N-1:0] outa, outb;

  int    n_vec = 0;
  int    n_err = 0;
  int    qa[$];
  int    qb[$];
  string qt[$];

  always #5 clk = ~clk;

  u_butterfly_pipelined #(.DATA_W(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .w    (w),
    .s    (s),
    .outa (outa),
    .outb (outb)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Applies one sample, then checks the sample that was applied two edges ago.
  task automatic step(input string tag, input int ia, input int ib,
                      input int iw, input logic is);
    int    ea, eb;
    string et;
    a = sample_t'(ia);
    b = sample_t'(ib);
    w = sample_t'(iw);
    s = is;
    if (is == MODE_DIT) begin
      qa.push_back(ia + iw * ib);
      qb.push_back(ia - iw * ib);
    end else begin
      qa.push_back(ia + ib);
      qb.push_back(iw * (ia - ib));
    end
    qt.push_back(tag);
    @(posedge clk);
    #1;
    if (qa.size() >= 2) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      et = qt.pop_front();
      check({et, "_outa"}, 32'(outa), ea);
      check({et, "_outb"}, 32'(outb), eb);
      $display("vec %s: outa=%0d outb=%0d (exp %0d, %0d)", et, outa, outb, ea, eb);
    end
  endtask

  // Pulls reset low between clock edges, holds it across edges with random
  // inputs, and releases it on a falling edge. The reset pipeline yields zeros.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_async_outa"}, 32'(outa), 0);
    check({tag, "_async_outb"}, 32'(outb), 0);
    for (int i = 0; i < 3; i++) begin
      a = sample_t'($urandom);
      b = sample_t'($urandom);
      w = sample_t'($urandom);
      s = 1'($urandom);
      @(posedge clk);
      #1;
      check({tag, "_held_outa"}, 32'(outa), 0);
      check({tag, "_held_outb"}, 32'(outb), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    qt.delete();
    qa.push_back(0);
    qb.push_back(0);
    qt.push_back({tag, "_flush"});
  endtask

  initial begin
    a = '0;
    b = '0;
    w = '0;
    s = MODE_DIT;
    do_reset("por");

    step("dit_10_2_3", 10, 2, 3, MODE_DIT);
    step("dif_10_2_3", 10, 2, 3, MODE_DIF);
    step("dif_m5_4_m2", -5, 4, -2, MODE_DIF);
    step("alt_dit", -5, 4, -2, MODE_DIT);
    step("alt_dif", -7, -3, 2, MODE_DIF);
    step("alt_dit2", -7, -3, 2, MODE_DIT);
    step("ext_dif", -128, 127, -128, MODE_DIF);
    step("ext_dit", -128, -128, -128, MODE_DIT);
    step("ext_dif2", 127, -128, -128, MODE_DIF);
    step("ext_dit2", 127, 127, 127, MODE_DIT);

    for (int i = 0; i < 60; i++)
      step($sformatf("rnd%0d", i), int'(sample_t'($urandom)),
           int'(sample_t'($urandom)), int'(sample_t'($urandom)), 1'($urandom));

    do_reset("mid");

    for (int i = 60; i < 120; i++)
      step($sformatf("rnd%0d", i), int'(sample_t'($urandom)),
           int'(sample_t'($urandom)), int'(sample_t'($urandom)), 1'($urandom));

    step("drain", 0, 0, 0, MODE_DIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
